stack_alu_ext: RTL
==================

Name: stack_alu_ext

Overview:
- Parametrised successor to the fixed stack ALU: a signed LIFO operand stack with a single-cycle arithmetic unit on its top two entries.
- Adds configurable depth, SUB/DUP/SWAP opcodes, selectable wrap or saturate overflow, an op_valid qualifier, and explicit full/empty/error/count status.
- Sits behind a host sequencer that issues one opcode per cycle and reads registered results.

Parameters:
- N, 8, data width in bits (signed two's complement).
- DEPTH, 512, stack entries; must be at least 2.
- SATURATE, 0: 0 = wrap on overflow, 1 = clamp to the signed min/max.
- CW, $clog2(DEPTH+1), count width (derived localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- op_valid  in  1  opcode/input_data sampled on this edge when high.
- opcode  in  3  operation, see Behaviour.
- input_data  in  N  signed operand for PUSH.
- output_data  out  N  signed result of the last accepted op.
- out_valid  out  1  one-cycle pulse, one cycle after an accepted op.
- overflow  out  1  arithmetic overflow of the last op, qualified by out_valid.
- error  out  1  illegal op for the current stack state, qualified by out_valid.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CW  current number of entries.

Behaviour:
- Reset (async assert, sync deassert by the user): count=0, empty=1, full=0, output_data=0, out_valid=0, overflow=0, error=0. The storage array is not reset.
- Operations are accepted on the rising edge when op_valid=1. Results are registered, so latency is 1 cycle. Throughput is one op per cycle, back-to-back, with no stall.
- op_valid=0 or NOP: nothing changes, and out_valid=0 on the next cycle.
- Operand naming: A = top entry, B = the entry below it.
- Opcodes:
  - 000 NOP.
  - 001 SUB: pop A and B, push B-A.
  - 010 DUP: push a copy of A.
  - 011 SWAP: exchange A and B.
  - 100 ADD: pop A and B, push B+A.
  - 101 MUL: pop A and B, push B*A.
  - 110 PUSH: push input_data.
  - 111 POP: remove A.
- output_data after each op:
  - PUSH: the pushed value.
  - POP: the popped value.
  - DUP, SWAP, ADD, SUB, MUL: the new top.
- Count effect: ADD/SUB/MUL net -1; PUSH/DUP net +1; POP -1; SWAP 0.
- Error conditions:
  - PUSH or DUP when full.
  - POP or DUP when empty.
  - SWAP/ADD/SUB/MUL when count < 2.
- On error: stack, count and output_data are unchanged, error=1, overflow=0, out_valid=1.
- Arithmetic:
  - ADD/SUB are computed at N+1 bits; overflow is set when the result falls outside [-2^(N-1), 2^(N-1)-1].
  - MUL is computed as a full 2N-bit signed product; overflow is set when the product is outside the N-bit signed range.
- On overflow:
  - SATURATE=0: push the low N bits.
  - SATURATE=1: push the max (positive overflow) or the min (negative overflow).
  - overflow=1 in both modes.
- full/empty/count are registered and reflect the state after the last accepted op.
- Reset mid-operation: asynchronous clear, and any in-flight result is discarded.

Decomposition:
- Package stack_alu_pkg holds:
  - opcode localparams OP_NOP, OP_SUB, OP_DUP, OP_SWAP, OP_ADD, OP_MUL, OP_PUSH, OP_POP;
  - a function that returns the signed min/max for a width.
- One sub-module, stack_alu_arith, is combinational. It takes A, B, opcode and SATURATE, and returns the N-bit result and overflow.
- The top level holds the storage array, pointer/count logic, legality decode and output registers.

Test Plan:
- N=8: PUSH 5, PUSH -3, ADD → output_data=2, overflow=0, error=0, count=1; then POP → 2, empty=1.
- N=8, SATURATE=0: PUSH 100, PUSH 50, ADD → -106, overflow=1. With SATURATE=1, the same sequence → 127, overflow=1.
- N=8: PUSH -8, PUSH 16, MUL → -128, overflow=0. PUSH 16, PUSH 8, MUL → overflow=1, result -128 (wrap) or 127 (sat).
- DEPTH=4: PUSH 1,2,3,4 → full=1, count=4. PUSH 5 → error=1, count=4. POP ×4 → 4,3,2,1, empty=1. POP again → error=1, output_data holds 1.
- PUSH 7, PUSH 3, SUB → 4. PUSH 9, SWAP → output 4. POP → 4, POP → 9. SWAP with count=0 → error=1.
- PUSH 1, 2, 3, then drop rst_n mid-cycle → count=0, empty=1, output_data=0 immediately. After release, POP → error=1. Also check that op_valid=0 cycles produce out_valid=0.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// rtl/stack_alu_pkg.sv - opcode encodings and signed range helper for the stack ALU
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DUP  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  // Largest (want_max=1) or smallest signed value representable in 'width' bits.
  function automatic logic signed [63:0] signed_limit(input int width, input bit want_max);
    logic signed [63:0] one;
    one = 64'sd1;
    if (want_max) begin
      return (one <<< (width - 1)) - 64'sd1;
    end
    return -(one <<< (width - 1));
  endfunction

endpackage

// File: rtl/stack_alu_arith.sv
// rtl/stack_alu_arith.sv - combinational ADD/SUB/MUL on the top two stack entries
module stack_alu_arith
  import stack_alu_pkg::*;
#(
  parameter int N        = 8,
  parameter int SATURATE = 0
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic        [2:0]   opcode,
  output logic signed [N-1:0] result,
  output logic                overflow
);

  localparam logic signed [N-1:0] MAX_V = N'(signed_limit(N, 1'b1));
  localparam logic signed [N-1:0] MIN_V = N'(signed_limit(N, 1'b0));

  logic signed [N:0]     sum_w;
  logic signed [N:0]     diff_w;
  logic signed [2*N-1:0] prod_w;
  logic signed [N-1:0]   low_bits;
  logic                  went_neg;

  // One extra bit for add/sub and a full double-width product keep the true result visible.
  assign sum_w  = {b[N-1], b} + {a[N-1], a};
  assign diff_w = {b[N-1], b} - {a[N-1], a};
  assign prod_w = b * a;

  // Pick the operation, flag out-of-range results and clamp when saturating.
  always_comb begin
    low_bits = a;
    overflow = 1'b0;
    went_neg = 1'b0;
    case (opcode)
      OP_ADD: begin
        low_bits = sum_w[N-1:0];
        overflow = sum_w[N] ^ sum_w[N-1];
        went_neg = sum_w[N];
      end
      OP_SUB: begin
        low_bits = diff_w[N-1:0];
        overflow = diff_w[N] ^ diff_w[N-1];
        went_neg = diff_w[N];
      end
      OP_MUL: begin
        low_bits = prod_w[N-1:0];
        overflow = !((&prod_w[2*N-1:N-1]) || !(|prod_w[2*N-1:N-1]));
        went_neg = prod_w[2*N-1];
      end
      default: ;
    endcase
    result = low_bits;
    if (overflow && (SATURATE != 0)) begin
      result = went_neg ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/stack_alu_ext.sv
// rtl/stack_alu_ext.sv - parametrised signed LIFO stack with single-cycle ALU on its top two entries
module stack_alu_ext
  import stack_alu_pkg::*;
#(
  parameter int N        = 8,
  parameter int DEPTH    = 512,
  parameter int SATURATE = 0,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  input  logic        [2:0]   opcode,
  input  logic signed [N-1:0] input_data,
  output logic signed [N-1:0] output_data,
  output logic                out_valid,
  output logic                overflow,
  output logic                error,
  output logic                full,
  output logic                empty,
  output logic        [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic signed [N-1:0] mem [DEPTH];

  logic [AW-1:0]       idx_a;
  logic [AW-1:0]       idx_b;
  logic [AW-1:0]       idx_push;
  logic signed [N-1:0] op_a;
  logic signed [N-1:0] op_b;
  logic signed [N-1:0] arith_res;
  logic                arith_ovf;

  logic                accept;
  logic                illegal;
  logic [CW-1:0]       count_nxt;
  logic signed [N-1:0] res;
  logic                res_ovf;
  logic                wr0_en;
  logic [AW-1:0]       wr0_idx;
  logic signed [N-1:0] wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_idx;
  logic signed [N-1:0] wr1_data;

  // A sits at count-1 and B at count-2; the next free slot is at count.
  assign idx_a    = AW'(count - CW'(1));
  assign idx_b    = AW'(count - CW'(2));
  assign idx_push = AW'(count);
  assign op_a     = mem[idx_a];
  assign op_b     = mem[idx_b];

  stack_alu_arith #(
    .N        (N),
    .SATURATE (SATURATE)
  ) u_arith (
    .a        (op_a),
    .b        (op_b),
    .opcode   (opcode),
    .result   (arith_res),
    .overflow (arith_ovf)
  );

  // Decode legality, stack writes, new count and the reported result for this opcode.
  always_comb begin
    accept    = op_valid && (opcode != OP_NOP);
    illegal   = 1'b0;
    count_nxt = count;
    res       = output_data;
    res_ovf   = 1'b0;
    wr0_en    = 1'b0;
    wr0_idx   = idx_push;
    wr0_data  = input_data;
    wr1_en    = 1'b0;
    wr1_idx   = idx_b;
    wr1_data  = op_a;
    case (opcode)
      OP_PUSH: begin
        illegal   = full;
        wr0_en    = 1'b1;
        count_nxt = count + CW'(1);
        res       = input_data;
      end
      OP_DUP: begin
        illegal   = full || empty;
        wr0_en    = 1'b1;
        wr0_data  = op_a;
        count_nxt = count + CW'(1);
        res       = op_a;
      end
      OP_POP: begin
        illegal   = empty;
        count_nxt = count - CW'(1);
        res       = op_a;
      end
      OP_SWAP: begin
        illegal  = count < CW'(2);
        wr0_en   = 1'b1;
        wr0_idx  = idx_a;
        wr0_data = op_b;
        wr1_en   = 1'b1;
        res      = op_b;
      end
      OP_ADD, OP_SUB, OP_MUL: begin
        illegal   = count < CW'(2);
        wr0_en    = 1'b1;
        wr0_idx   = idx_b;
        wr0_data  = arith_res;
        count_nxt = count - CW'(1);
        res       = arith_res;
        res_ovf   = arith_ovf;
      end
      default: ;
    endcase
    if (!accept || illegal) begin
      wr0_en    = 1'b0;
      wr1_en    = 1'b0;
      count_nxt = count;
    end
  end

  // Stack storage is deliberately left unreset; count alone defines what is live.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr0_idx] <= wr0_data;
    if (wr1_en) mem[wr1_idx] <= wr1_data;
  end

  // Register status and result; an illegal op only raises error and leaves state alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      output_data <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      error       <= 1'b0;
    end else begin
      out_valid <= accept;
      error     <= accept && illegal;
      overflow  <= accept && !illegal && res_ovf;
      if (accept && !illegal) begin
        output_data <= res;
        count       <= count_nxt;
        full        <= (count_nxt == CW'(DEPTH));
        empty       <= (count_nxt == '0);
      end
    end
  end

endmodule
